// File: rtl/collision_engine_if.sv
// Frame-resolve bus for collision_engine: start request, snapshotted object inputs,
// status and the registered kill masks returned to the game controller.
interface collision_engine_if #(
    parameter int unsigned N_ENEMY   = 8,
    parameter int unsigned N_EBULLET = 8,
    parameter int unsigned N_PBULLET = 8,
    parameter int unsigned CNT_W     = 4
);
    logic                      i_Start;
    logic [N_ENEMY-1:0]        i_EnemyState;
    logic [19*N_ENEMY-1:0]     i_EnemyPos;
    logic [N_EBULLET-1:0]      i_EBulletState;
    logic [19*N_EBULLET-1:0]   i_EBulletPos;
    logic [N_PBULLET-1:0]      i_PBulletState;
    logic [19*N_PBULLET-1:0]   i_PBulletPos;
    logic                      i_PlayerState;
    logic [9:0]                i_PlayerX;
    logic                      o_Busy;
    logic                      o_Done;
    logic [N_ENEMY-1:0]        o_EnemyKill;
    logic [N_EBULLET-1:0]      o_EBulletKill;
    logic [N_PBULLET-1:0]      o_PBulletKill;
    logic                      o_PlayerHit;
    logic [CNT_W-1:0]          o_HitCount;

    modport master (
        output i_Start, i_EnemyState, i_EnemyPos, i_EBulletState, i_EBulletPos,
               i_PBulletState, i_PBulletPos, i_PlayerState, i_PlayerX,
        input  o_Busy, o_Done, o_EnemyKill, o_EBulletKill, o_PBulletKill, o_PlayerHit,
               o_HitCount
    );

    modport slave (
        input  i_Start, i_EnemyState, i_EnemyPos, i_EBulletState, i_EBulletPos,
               i_PBulletState, i_PBulletPos, i_PlayerState, i_PlayerX,
        output o_Busy, o_Done, o_EnemyKill, o_EBulletKill, o_PBulletKill, o_PlayerHit,
               o_HitCount
    );
endinterface

// File: rtl/collision_engine.sv
// Time-multiplexed frame collision resolver: one object pair per clock through a single
// shared box-overlap comparator, producing registered kill masks and a hit count.
module collision_engine #(
    parameter int unsigned N_ENEMY   = 8,
    parameter int unsigned N_EBULLET = 8,
    parameter int unsigned N_PBULLET = 8,
    parameter int unsigned ENEMY_W   = 36,
    parameter int unsigned ENEMY_H   = 24,
    parameter int unsigned PLAYER_W  = 24,
    parameter int unsigned PLAYER_H  = 36,
    parameter int unsigned BULLET_W  = 4,
    parameter int unsigned BULLET_H  = 16,
    parameter int unsigned PLAYER_Y  = 372,
    parameter int unsigned MON_H     = 480,
    parameter int unsigned TOP_LIMIT = 4,
    parameter int unsigned CNT_W     = 4
) (
    input logic               i_Clk,
    input logic               i_Rst,
    collision_engine_if.slave bus
);
    localparam int unsigned N_TGT = N_EBULLET + N_ENEMY;
    localparam int unsigned P_W   = 4;
    localparam int unsigned T_W   = 5;

    typedef enum logic [2:0] {StIdle, StSnap, StScanPb, StScanEb, StDone} state_e;

    state_e                  r_state;
    logic [P_W-1:0]          r_p;
    logic [T_W-1:0]          r_t;
    logic [N_ENEMY-1:0]      r_en_state;
    logic [19*N_ENEMY-1:0]   r_en_pos;
    logic [N_EBULLET-1:0]    r_eb_state;
    logic [19*N_EBULLET-1:0] r_eb_pos;
    logic [N_PBULLET-1:0]    r_pb_state;
    logic [19*N_PBULLET-1:0] r_pb_pos;
    logic                    r_player_state;
    logic [9:0]              r_player_x;
    logic [N_ENEMY-1:0]      r_en_kill;
    logic [N_EBULLET-1:0]    r_eb_kill;
    logic [N_PBULLET-1:0]    r_pb_kill;
    logic                    r_player_hit;
    logic [CNT_W-1:0]        r_hit_count;
    logic                    r_busy;
    logic                    r_done;

    logic [N_PBULLET-1:0] w_pb_oh;
    logic [N_EBULLET-1:0] w_eb_oh;
    logic [N_ENEMY-1:0]   w_en_oh;
    logic [18:0]          w_pb_pos, w_eb_pos, w_en_pos;
    logic                 w_pb_live, w_eb_live, w_en_live, w_tgt_is_eb;
    logic [9:0]           w_ax, w_bx;
    logic [8:0]           w_ay, w_by;
    logic [10:0]          w_bw, w_ax2, w_bx2;
    logic [9:0]           w_bh, w_ay2, w_by2;
    logic                 w_overlap, w_pb_border, w_eb_border, w_pb_hit;

    // r_t doubles as the target index in SCAN_PB and the enemy bullet index in SCAN_EB.
    always_comb begin
        w_pb_oh  = '0;
        w_eb_oh  = '0;
        w_en_oh  = '0;
        w_pb_pos = '0;
        w_eb_pos = '0;
        w_en_pos = '0;
        for (int k = 0; k < N_PBULLET; k++) begin
            w_pb_oh[k] = (r_p == P_W'(k));
            if (w_pb_oh[k]) w_pb_pos = r_pb_pos[19*k +: 19];
        end
        for (int k = 0; k < N_EBULLET; k++) begin
            w_eb_oh[k] = (r_t == T_W'(k));
            if (w_eb_oh[k]) w_eb_pos = r_eb_pos[19*k +: 19];
        end
        for (int k = 0; k < N_ENEMY; k++) begin
            w_en_oh[k] = (r_t == T_W'(N_EBULLET + k));
            if (w_en_oh[k]) w_en_pos = r_en_pos[19*k +: 19];
        end
    end

    assign w_pb_live   = |(w_pb_oh & r_pb_state & ~r_pb_kill);
    assign w_eb_live   = |(w_eb_oh & r_eb_state & ~r_eb_kill);
    assign w_en_live   = |(w_en_oh & r_en_state & ~r_en_kill);
    assign w_tgt_is_eb = (r_t < T_W'(N_EBULLET));

    // Box A is always a bullet; box B is the current target or the player.
    always_comb begin
        w_ax = w_pb_pos[18:9];
        w_ay = w_pb_pos[8:0];
        w_bx = w_en_pos[18:9];
        w_by = w_en_pos[8:0];
        w_bw = 11'(ENEMY_W);
        w_bh = 10'(ENEMY_H);
        if (r_state == StScanEb) begin
            w_ax = w_eb_pos[18:9];
            w_ay = w_eb_pos[8:0];
            w_bx = r_player_x;
            w_by = 9'(PLAYER_Y);
            w_bw = 11'(PLAYER_W);
            w_bh = 10'(PLAYER_H);
        end else if (w_tgt_is_eb) begin
            w_bx = w_eb_pos[18:9];
            w_by = w_eb_pos[8:0];
            w_bw = 11'(BULLET_W);
            w_bh = 10'(BULLET_H);
        end
    end

    assign w_ax2 = {1'b0, w_ax} + 11'(BULLET_W);
    assign w_ay2 = {1'b0, w_ay} + 10'(BULLET_H);
    assign w_bx2 = {1'b0, w_bx} + w_bw;
    assign w_by2 = {1'b0, w_by} + w_bh;
    assign w_overlap = ({1'b0, w_ax} <= w_bx2) && ({1'b0, w_bx} <= w_ax2) &&
                       ({1'b0, w_ay} <= w_by2) && ({1'b0, w_by} <= w_ay2);

    assign w_pb_border = (w_pb_pos[8:0] < 9'(TOP_LIMIT));
    assign w_eb_border = ({1'b0, w_eb_pos[8:0]} > 10'(MON_H - BULLET_H));
    assign w_pb_hit    = w_pb_live && !w_pb_border && (w_eb_live || w_en_live) && w_overlap;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state        <= StIdle;
            r_p            <= '0;
            r_t            <= '0;
            r_en_state     <= '0;
            r_en_pos       <= '0;
            r_eb_state     <= '0;
            r_eb_pos       <= '0;
            r_pb_state     <= '0;
            r_pb_pos       <= '0;
            r_player_state <= 1'b0;
            r_player_x     <= '0;
            r_en_kill      <= '0;
            r_eb_kill      <= '0;
            r_pb_kill      <= '0;
            r_player_hit   <= 1'b0;
            r_hit_count    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.i_Start) begin
                        r_state <= StSnap;
                        r_busy  <= 1'b1;
                    end
                end
                StSnap: begin
                    r_en_state     <= bus.i_EnemyState;
                    r_en_pos       <= bus.i_EnemyPos;
                    r_eb_state     <= bus.i_EBulletState;
                    r_eb_pos       <= bus.i_EBulletPos;
                    r_pb_state     <= bus.i_PBulletState;
                    r_pb_pos       <= bus.i_PBulletPos;
                    r_player_state <= bus.i_PlayerState;
                    r_player_x     <= bus.i_PlayerX;
                    r_en_kill      <= '0;
                    r_eb_kill      <= '0;
                    r_pb_kill      <= '0;
                    r_player_hit   <= 1'b0;
                    r_hit_count    <= '0;
                    r_p            <= '0;
                    r_t            <= '0;
                    r_state        <= StScanPb;
                end
                StScanPb: begin
                    if (r_t == '0 && w_pb_live && w_pb_border) begin
                        r_pb_kill <= r_pb_kill | w_pb_oh;
                    end
                    // Only the selected target's one-hot is non-zero, so both OR-ins are safe.
                    if (w_pb_hit) begin
                        r_pb_kill <= r_pb_kill | w_pb_oh;
                        r_eb_kill <= r_eb_kill | w_eb_oh;
                        r_en_kill <= r_en_kill | w_en_oh;
                        if (!w_tgt_is_eb && r_hit_count != '1) begin
                            r_hit_count <= r_hit_count + CNT_W'(1);
                        end
                    end
                    if (r_t == T_W'(N_TGT - 1)) begin
                        r_t <= '0;
                        if (r_p == P_W'(N_PBULLET - 1)) r_state <= StScanEb;
                        else r_p <= r_p + P_W'(1);
                    end else begin
                        r_t <= r_t + T_W'(1);
                    end
                end
                StScanEb: begin
                    if (w_eb_live) begin
                        if (w_eb_border) begin
                            r_eb_kill <= r_eb_kill | w_eb_oh;
                        end else if (r_player_state && w_overlap) begin
                            r_eb_kill    <= r_eb_kill | w_eb_oh;
                            r_player_hit <= 1'b1;
                        end
                    end
                    if (r_t == T_W'(N_EBULLET - 1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + T_W'(1);
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_Busy        = r_busy;
    assign bus.o_Done        = r_done;
    assign bus.o_EnemyKill   = r_en_kill;
    assign bus.o_EBulletKill = r_eb_kill;
    assign bus.o_PBulletKill = r_pb_kill;
    assign bus.o_PlayerHit   = r_player_hit;
    assign bus.o_HitCount    = r_hit_count;
endmodule
